shake_job_arbiter: RTL and testbench

//  Shares one shake_128 engine between NREQ job requesters (keygen/sign/verify expanders).
//  - Each requester posts a job: mlen, olen, read_adr, write_adr.
//  - Grants jobs round-robin, launches the engine with a 1-cycle en pulse, waits for done,

---
 rtl/shake_job_arbiter_pkg.sv | 17 +
 rtl/shake_job_arbiter_if.sv | 36 +++
 rtl/shake_job_arbiter_rr_pick.sv | 30 +++
 rtl/shake_job_arbiter.sv | 129 ++++++++++++
 tb/tb_shake_job_arbiter.sv | 330 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/shake_job_arbiter_pkg.sv
// Shared types and constants for the shake_128 job arbiter.
package shake_job_arbiter_pkg;

    localparam int JOB_W           = 32;
    localparam int DEFAULT_NREQ    = 4;
    localparam int DEFAULT_GAP_CYC = 2;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_GRANT  = 3'd1,
        ST_LAUNCH = 3'd2,
        ST_WAIT   = 3'd3,
        ST_DONE   = 3'd4,
        ST_GAP    = 3'd5
    } arb_state_t;

endpackage

// File: rtl/shake_job_arbiter_if.sv
// Requester job port plus engine job port seen by the arbiter (master) and its environment (slave).
interface shake_job_arbiter_if #(
    parameter int NREQ = 4,
    parameter int ID_W = 2
);
    import shake_job_arbiter_pkg::*;

    logic [NREQ-1:0]       req;
    logic [NREQ*JOB_W-1:0] req_mlen;
    logic [NREQ*JOB_W-1:0] req_olen;
    logic [NREQ*JOB_W-1:0] req_read_adr;
    logic [NREQ*JOB_W-1:0] req_write_adr;
    logic [NREQ-1:0]       ack;
    logic [NREQ-1:0]       req_done;
    logic                  busy;
    logic [ID_W-1:0]       cur_id;
    logic                  shk_en;
    logic [JOB_W-1:0]      shk_mlen;
    logic [JOB_W-1:0]      shk_olen;
    logic [JOB_W-1:0]      shk_read_adr;
    logic [JOB_W-1:0]      shk_write_adr;
    logic                  shk_done;

    modport master (
        input  req, req_mlen, req_olen, req_read_adr, req_write_adr, shk_done,
        output ack, req_done, busy, cur_id,
        output shk_en, shk_mlen, shk_olen, shk_read_adr, shk_write_adr
    );

    modport slave (
        output req, req_mlen, req_olen, req_read_adr, req_write_adr, shk_done,
        input  ack, req_done, busy, cur_id,
        input  shk_en, shk_mlen, shk_olen, shk_read_adr, shk_write_adr
    );

endinterface

// File: rtl/shake_job_arbiter_rr_pick.sv
// Combinational round-robin pick: first set request at or after ptr, wrapping past NREQ-1 to 0.
module rr_pick
    import shake_job_arbiter_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int ID_W = 2
) (
    input  logic [NREQ-1:0] req,
    input  logic [ID_W-1:0] ptr,
    output logic            valid,
    output logic [ID_W-1:0] id
);

    logic [ID_W-1:0] idx;

    // Scan farthest-from-pointer first so the closest set request wins last.
    always_comb begin
        valid = 1'b0;
        id    = '0;
        idx   = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            idx = ID_W'((int'(ptr) + k) % NREQ);
            if (req[idx]) begin
                valid = 1'b1;
                id    = idx;
            end
        end
    end

endmodule

// File: rtl/shake_job_arbiter.sv
// Round-robin arbiter sharing one shake_128 engine between NREQ job requesters.
// Define SHAKE_ARB_PERF_EN to add the perf_busy_cyc / perf_jobs counters.
module shake_job_arbiter
    import shake_job_arbiter_pkg::*;
#(
    parameter int NREQ    = DEFAULT_NREQ,
    parameter int ID_W    = 2,
    parameter int GAP_CYC = DEFAULT_GAP_CYC
) (
    input  logic                clk,
    input  logic                rst,
    shake_job_arbiter_if.master bus
`ifdef SHAKE_ARB_PERF_EN
    ,
    output logic [31:0]         perf_busy_cyc,
    output logic [31:0]         perf_jobs
`endif
);

    localparam logic [15:0] GAP_LOAD = 16'(GAP_CYC);

    arb_state_t       state;
    arb_state_t       next_state;
    logic [ID_W-1:0]  rr_ptr;
    logic [ID_W-1:0]  cur_id;
    logic [ID_W-1:0]  pick_id;
    logic             pick_valid;
    logic [15:0]      gap_cnt;
    logic [JOB_W-1:0] mlen_q;
    logic [JOB_W-1:0] olen_q;
    logic [JOB_W-1:0] radr_q;
    logic [JOB_W-1:0] wadr_q;
    logic [NREQ-1:0]  ack_vec;
    logic [NREQ-1:0]  done_vec;
    logic             shk_en;
    logic             busy;

    rr_pick #(
        .NREQ (NREQ),
        .ID_W (ID_W)
    ) u_pick (
        .req   (bus.req),
        .ptr   (rr_ptr),
        .valid (pick_valid),
        .id    (pick_id)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Zero-length digests skip the engine entirely but still drain through GAP.
    always_comb begin
        next_state = state;
        unique case (state)
            ST_IDLE:   if (pick_valid && gap_cnt == '0) next_state = ST_GRANT;
            ST_GRANT:  next_state = (olen_q == '0) ? ST_DONE : ST_LAUNCH;
            ST_LAUNCH: next_state = ST_WAIT;
            ST_WAIT:   if (bus.shk_done) next_state = ST_DONE;
            ST_DONE:   next_state = ST_GAP;
            ST_GAP:    if (gap_cnt <= 16'd1) next_state = ST_IDLE;
            default:   next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr  <= '0;
            cur_id  <= '0;
            gap_cnt <= '0;
            mlen_q  <= '0;
            olen_q  <= '0;
            radr_q  <= '0;
            wadr_q  <= '0;
        end else begin
            if (state == ST_IDLE && next_state == ST_GRANT) begin
                cur_id <= pick_id;
                mlen_q <= bus.req_mlen[int'(pick_id) * JOB_W +: JOB_W];
                olen_q <= bus.req_olen[int'(pick_id) * JOB_W +: JOB_W];
                radr_q <= bus.req_read_adr[int'(pick_id) * JOB_W +: JOB_W];
                wadr_q <= bus.req_write_adr[int'(pick_id) * JOB_W +: JOB_W];
            end
            // Pointer moves past the finished requester so a re-raised req queues behind others.
            if (state == ST_DONE) begin
                rr_ptr  <= (cur_id == ID_W'(NREQ - 1)) ? '0 : cur_id + 1'b1;
                gap_cnt <= GAP_LOAD;
            end else if (state == ST_GAP && gap_cnt != '0) begin
                gap_cnt <= gap_cnt - 1'b1;
            end
        end
    end

    always_comb begin
        ack_vec  = '0;
        done_vec = '0;
        if (state == ST_GRANT) ack_vec[cur_id] = 1'b1;
        if (state == ST_DONE) done_vec[cur_id] = 1'b1;
        shk_en = (state == ST_LAUNCH);
        busy   = (state == ST_GRANT) || (state == ST_LAUNCH) ||
                 (state == ST_WAIT)  || (state == ST_DONE);
    end

    assign bus.ack           = ack_vec;
    assign bus.req_done      = done_vec;
    assign bus.busy          = busy;
    assign bus.cur_id        = cur_id;
    assign bus.shk_en        = shk_en;
    assign bus.shk_mlen      = mlen_q;
    assign bus.shk_olen      = olen_q;
    assign bus.shk_read_adr  = radr_q;
    assign bus.shk_write_adr = wadr_q;

`ifdef SHAKE_ARB_PERF_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_busy_cyc <= '0;
            perf_jobs     <= '0;
        end else begin
            if (busy && perf_busy_cyc != '1) perf_busy_cyc <= perf_busy_cyc + 1'b1;
            if (state == ST_DONE && perf_jobs != '1) perf_jobs <= perf_jobs + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_shake_job_arbiter.sv
// Self-checking bench for shake_job_arbiter: timeline model plus directed job scenarios.
// Build with SHAKE_ARB_PERF_EN defined to also exercise the perf counters.
module tb_shake_job_arbiter;
    import shake_job_arbiter_pkg::*;

    localparam int NREQ = 4;
    localparam int ID_W = 2;
    localparam int GAP  = 2;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    shake_job_arbiter_if #(.NREQ(NREQ), .ID_W(ID_W)) bus();

    logic stub_pulse  = 1'b0;
    logic stray_pulse = 1'b0;
    assign bus.shk_done = stub_pulse | stray_pulse;

`ifdef SHAKE_ARB_PERF_EN
    logic [31:0] perf_busy_cyc;
    logic [31:0] perf_jobs;
`endif

    shake_job_arbiter #(.NREQ(NREQ), .ID_W(ID_W), .GAP_CYC(GAP)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
`ifdef SHAKE_ARB_PERF_EN
        ,
        .perf_busy_cyc (perf_busy_cyc),
        .perf_jobs     (perf_jobs)
`endif
    );

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    // Stub engine: done pulse stub_n cycles after each en; shares the arbiter reset.
    int stub_n   = 8;
    int stub_cnt = 0;
    initial forever begin
        @(posedge clk); #1;
        stub_pulse = 1'b0;
        if (rst) begin
            stub_cnt = 0;
        end else begin
            if (stub_cnt > 0) begin
                stub_cnt--;
                if (stub_cnt == 0) stub_pulse = 1'b1;
            end
            if (bus.shk_en === 1'b1) stub_cnt = stub_n;
        end
    end

    int ack_ids[$], ack_cycs[$], en_cycs[$], done_ids[$], done_cycs[$], sd_cycs[$];
    logic [31:0] en_mlen[$], en_olen[$];

    bit checking = 1'b0;
    bit m_job = 1'b0;
    bit m_bypass = 1'b0;
    int m_id = 0, m_grant = 0, m_done = -1, m_rr = 0, m_ready = 0, pick = -1;
    logic [31:0] m_mlen, m_olen, m_radr, m_wadr;
    logic [NREQ-1:0] exp_ack, exp_done;
    logic exp_en, exp_busy;

    // Model: a job granted at cycle g acks at g, launches at g+1, finishes the cycle after
    // the engine reports done (or at g+1 for zero olen), then locks out for GAP cycles.
    always @(negedge clk) begin
        if (checking && !rst) begin
            exp_ack  = '0;
            exp_done = '0;
            exp_en   = 1'b0;
            exp_busy = m_job && (cyc >= m_grant);
            if (m_job) begin
                if (cyc == m_grant) exp_ack[m_id] = 1'b1;
                if (!m_bypass && cyc == m_grant + 1) exp_en = 1'b1;
                if (cyc == m_done) exp_done[m_id] = 1'b1;
            end
            checkOutput("ack", 32'(bus.ack), 32'(exp_ack));
            checkOutput("req_done", 32'(bus.req_done), 32'(exp_done));
            checkOutput("shk_en", 32'(bus.shk_en), 32'(exp_en));
            checkOutput("busy", 32'(bus.busy), 32'(exp_busy));
            if (exp_busy) begin
                checkOutput("cur_id", 32'(bus.cur_id), 32'(m_id));
                checkOutput("shk_mlen", bus.shk_mlen, m_mlen);
                checkOutput("shk_olen", bus.shk_olen, m_olen);
                checkOutput("shk_read_adr", bus.shk_read_adr, m_radr);
                checkOutput("shk_write_adr", bus.shk_write_adr, m_wadr);
            end
            for (int i = 0; i < NREQ; i++) begin
                if (bus.ack[i] === 1'b1) begin ack_ids.push_back(i); ack_cycs.push_back(cyc); end
                if (bus.req_done[i] === 1'b1) begin done_ids.push_back(i); done_cycs.push_back(cyc); end
            end
            if (bus.shk_en === 1'b1) begin
                en_cycs.push_back(cyc);
                en_mlen.push_back(bus.shk_mlen);
                en_olen.push_back(bus.shk_olen);
            end
            if (bus.shk_done === 1'b1) sd_cycs.push_back(cyc);
        end
        if (rst) begin
            checking = 1'b1;
            m_job    = 1'b0;
            m_rr     = 0;
            m_ready  = cyc + 1;
        end else if (checking) begin
            if (m_job && cyc == m_done) begin
                m_job   = 1'b0;
                m_rr    = (m_id + 1) % NREQ;
                m_ready = cyc + 1 + GAP;
            end else if (m_job && !m_bypass && m_done < 0 && cyc >= m_grant + 2 && bus.shk_done === 1'b1) begin
                m_done = cyc + 1;
            end
            if (!m_job && cyc >= m_ready && bus.req != '0) begin
                pick = -1;
                for (int k = 0; k < NREQ; k++)
                    if (pick < 0 && bus.req[(m_rr + k) % NREQ]) pick = (m_rr + k) % NREQ;
                m_id     = pick;
                m_job    = 1'b1;
                m_grant  = cyc + 1;
                m_mlen   = bus.req_mlen[pick*32 +: 32];
                m_olen   = bus.req_olen[pick*32 +: 32];
                m_radr   = bus.req_read_adr[pick*32 +: 32];
                m_wadr   = bus.req_write_adr[pick*32 +: 32];
                m_bypass = (m_olen == 32'd0);
                m_done   = m_bypass ? cyc + 2 : -1;
            end
        end
    end

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin @(posedge clk); #1; end
    endtask

    task automatic clearLog();
        ack_ids.delete(); ack_cycs.delete(); en_cycs.delete(); done_ids.delete();
        done_cycs.delete(); sd_cycs.delete(); en_mlen.delete(); en_olen.delete();
    endtask

    task automatic doReset();
        tick(1);
        rst = 1'b1;
        stub_cnt = 0;
        stray_pulse = 1'b0;
        tick(2);
        checkOutput("rst_busy", 32'(bus.busy), 32'd0);
        checkOutput("rst_ack", 32'(bus.ack), 32'd0);
        checkOutput("rst_req_done", 32'(bus.req_done), 32'd0);
        checkOutput("rst_shk_en", 32'(bus.shk_en), 32'd0);
        checkOutput("rst_cur_id", 32'(bus.cur_id), 32'd0);
        checkOutput("rst_shk_mlen", bus.shk_mlen, 32'd0);
        checkOutput("rst_shk_olen", bus.shk_olen, 32'd0);
`ifdef SHAKE_ARB_PERF_EN
        checkOutput("rst_perf_busy", perf_busy_cyc, 32'd0);
        checkOutput("rst_perf_jobs", perf_jobs, 32'd0);
`endif
        rst = 1'b0;
    endtask

    task automatic applyStimulus(input int id, input logic [31:0] mlen, input logic [31:0] olen,
                                 input logic [31:0] radr, input logic [31:0] wadr);
        bus.req_mlen[id*32 +: 32]      = mlen;
        bus.req_olen[id*32 +: 32]      = olen;
        bus.req_read_adr[id*32 +: 32]  = radr;
        bus.req_write_adr[id*32 +: 32] = wadr;
        bus.req[id] = 1'b1;
    endtask

    task automatic waitPulse(input string name, input bit on_done, input int id, input int budget);
        int n = 0;
        bit seen = 1'b0;
        while (!seen && n < budget) begin
            tick(1);
            n++;
            seen = on_done ? (bus.req_done[id] === 1'b1) : (bus.ack[id] === 1'b1);
        end
        checkOutput(name, 32'(seen), 32'd1);
    endtask

    task automatic waitCount(input string name, input bit on_done, input int target, input int budget);
        int n = 0;
        while ((on_done ? done_ids.size() : ack_ids.size()) < target && n < budget) begin
            tick(1);
            n++;
        end
        checkOutput(name, 32'(on_done ? done_ids.size() : ack_ids.size()), 32'(target));
    endtask

    int c0;
    int exp_order[5];

    initial begin
        bus.req = '0;
        bus.req_mlen = '0;
        bus.req_olen = '0;
        bus.req_read_adr = '0;
        bus.req_write_adr = '0;

        $display("[TB] single job on requester 0");
        doReset();
        clearLog();
        stub_n = 8;
        c0 = cyc;
        applyStimulus(0, 32'd64, 32'd32, 32'h100, 32'h800);
        waitPulse("t1_ack", 1'b0, 0, 20);
        bus.req[0] = 1'b0;
        waitPulse("t1_done", 1'b1, 0, 40);
        tick(4);
        checkOutput("t1_n_en", 32'(en_cycs.size()), 32'd1);
        checkOutput("t1_n_done", 32'(done_cycs.size()), 32'd1);
        if (en_cycs.size() == 1 && done_cycs.size() == 1 && ack_cycs.size() == 1 && sd_cycs.size() >= 1) begin
            checkOutput("t1_ack_lat", 32'(ack_cycs[0] - c0), 32'd1);
            checkOutput("t1_en_lat", 32'(en_cycs[0] - c0), 32'd2);
            checkOutput("t1_en_mlen", en_mlen[0], 32'd64);
            checkOutput("t1_en_olen", en_olen[0], 32'd32);
            checkOutput("t1_done_lat", 32'(done_cycs[0] - c0), 32'd11);
            checkOutput("t1_sd_to_done", 32'(done_cycs[0] - sd_cycs[0]), 32'd1);
        end

        $display("[TB] all four requesters held");
        doReset();
        clearLog();
        stub_n = 10;
        for (int i = 0; i < NREQ; i++)
            applyStimulus(i, 32'(16 * (i + 1)), 32'(8 + i), 32'(32'h1000 * i), 32'(32'h2000 + i));
        waitCount("t2_acks", 1'b0, 5, 200);
        bus.req = '0;
        waitCount("t2_dones", 1'b1, 5, 60);
        exp_order = '{0, 1, 2, 3, 0};
        for (int i = 0; i < 5; i++) begin
            if (i < ack_ids.size()) checkOutput("t2_grant_order", 32'(ack_ids[i]), 32'(exp_order[i]));
            if (i < done_ids.size()) checkOutput("t2_done_order", 32'(done_ids[i]), 32'(exp_order[i]));
        end

        $display("[TB] zero olen bypass");
        doReset();
        clearLog();
        stub_n = 5;
        applyStimulus(2, 32'd16, 32'd0, 32'h40, 32'h80);
        waitPulse("t3_ack", 1'b0, 2, 20);
        bus.req[2] = 1'b0;
        tick(6);
        checkOutput("t3_no_en", 32'(en_cycs.size()), 32'd0);
        checkOutput("t3_n_done", 32'(done_ids.size()), 32'd1);
        if (done_ids.size() == 1 && ack_cycs.size() == 1) begin
            checkOutput("t3_done_id", 32'(done_ids[0]), 32'd2);
            checkOutput("t3_done_lat", 32'(done_cycs[0] - ack_cycs[0]), 32'd1);
        end

        $display("[TB] stray engine done and mid-job reset");
        doReset();
        clearLog();
        tick(2);
        stray_pulse = 1'b1;
        tick(1);
        stray_pulse = 1'b0;
        tick(2);
        checkOutput("t4_idle_stray", 32'(done_ids.size()), 32'd0);
        stub_n = 4;
        applyStimulus(0, 32'd8, 32'd16, 32'h10, 32'h20);
        waitPulse("t4_ack0", 1'b0, 0, 20);
        bus.req[0] = 1'b0;
        waitPulse("t4_done0", 1'b1, 0, 30);
        tick(1);
        stray_pulse = 1'b1;
        tick(1);
        stray_pulse = 1'b0;
        tick(4);
        checkOutput("t4_gap_stray", 32'(done_ids.size()), 32'd1);
        stub_n = 30;
        applyStimulus(1, 32'd24, 32'd8, 32'h30, 32'h40);
        waitPulse("t4_ack1", 1'b0, 1, 20);
        bus.req[1] = 1'b0;
        tick(4);
        checkOutput("t4_in_wait", 32'(bus.busy), 32'd1);
        doReset();
        tick(3);
        checkOutput("t4_no_done_after_rst", 32'(done_ids.size()), 32'd1);

        $display("[TB] back-to-back jobs on requester 1");
        doReset();
        clearLog();
        stub_n = 5;
        applyStimulus(1, 32'd100, 32'd64, 32'h200, 32'h300);
        waitCount("t5_acks", 1'b0, 3, 100);
        bus.req[1] = 1'b0;
        waitCount("t5_dones", 1'b1, 3, 40);
        checkOutput("t5_n_en", 32'(en_cycs.size()), 32'd3);
        if (en_cycs.size() == 3) begin
            checkOutput("t5_spacing_a", 32'(en_cycs[1] - en_cycs[0]), 32'd11);
            checkOutput("t5_spacing_b", 32'(en_cycs[2] - en_cycs[1]), 32'd11);
        end

`ifdef SHAKE_ARB_PERF_EN
        $display("[TB] perf counters");
        doReset();
        clearLog();
        stub_n = 17;
        applyStimulus(3, 32'd50, 32'd32, 32'h500, 32'h600);
        waitCount("t6_acks", 1'b0, 3, 150);
        bus.req[3] = 1'b0;
        waitCount("t6_dones", 1'b1, 3, 40);
        tick(4);
        checkOutput("t6_perf_jobs", perf_jobs, 32'd3);
        checkOutput("t6_perf_busy", perf_busy_cyc, 32'd60);
`endif

        tick(2);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, vectors %0d miscompares %0d", vectors, miscompares);
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
